// File: rtl/la_dffnq_pipe.sv
// rtl/la_dffnq_pipe.sv - negative-edge register pipeline with valid/ready flow control
//
// Purpose:
//   WIDTH-bit, DEPTH-stage elastic pipeline whose state updates on the falling
//   clock edge. Empty stages always accept, so bubbles collapse behind a
//   stalled output. Outputs come straight from the last stage's registers.
//
// Ports:
//   clk        in   1               clock, state changes on the falling edge
//   reset      in   1               asynchronous active-high reset
//   flush      in   1               synchronous clear of every stage
//   in_valid   in   1               upstream word present
//   in_ready   out  1               pipeline takes in_data at the next falling edge
//   in_data    in   WIDTH           upstream word
//   out_valid  out  1               last stage holds a word
//   out_ready  in   1               downstream takes out_data at the next falling edge
//   out_data   out  WIDTH           last stage word
//   count      out  clog2(DEPTH+1)  number of occupied stages
//
// Parameters:
//   WIDTH, DEPTH, RESETVAL (value of every stage after reset/flush),
//   PROP (implementation property string; "NOCHECK" drops the embedded checks).

module la_dffnq_pipe #(
  parameter int                WIDTH    = 1,
  parameter int                DEPTH    = 2,
  parameter logic [WIDTH-1:0]  RESETVAL = '0,
  parameter                    PROP     = "DEFAULT"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW     = $clog2(DEPTH + 1);
  localparam bit CHECKS = (PROP != "NOCHECK");

  // Stage state: v[i] valid flag, d[i] data word. Stage DEPTH-1 is the output.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // Per-stage ready and the word each stage would load if it moves.
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  logic          xfer_in;
  logic          xfer_out;
  logic [CW-1:0] count_nxt;

  // Ready chain r[i] = !v[i] | r[i+1] with r[DEPTH] = out_ready, unrolled:
  // a stage can move when the output drains or any stage at or after it is
  // empty. The flat form avoids a self-referencing combinational vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ready
    assign ready[i] = out_ready | ~(&v[DEPTH-1:i]);
  end

  // Stage 0 loads from the input port, every other stage from its predecessor.
  assign src_v[0] = in_valid;
  assign src_d[0] = in_data;
  for (genvar i = 1; i < DEPTH; i++) begin : g_src
    assign src_v[i] = v[i-1];
    assign src_d[i] = d[i-1];
  end

  // Flush blocks acceptance on the same edge it clears the pipe.
  assign in_ready  = ready[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;
  assign count_nxt = count + CW'(xfer_in) - CW'(xfer_out);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESETVAL;
      end
    end else if (flush) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESETVAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ready[i]) begin
          v[i] <= src_v[i];
          // Data only moves with a valid word; a bubble leaves d untouched.
          if (src_v[i]) begin
            d[i] <= src_d[i];
          end
        end
      end
      count <= count_nxt;
    end
  end

  // Embedded invariants, checked mid-cycle on the rising edge where the
  // falling-edge state is settled.
  if (CHECKS) begin : g_checks
    a_count_popcount: assert property (
      @(posedge clk) disable iff (reset) count == CW'($countones(v)));

    a_count_range: assert property (
      @(posedge clk) disable iff (reset) count <= CW'(DEPTH));

    a_flush_blocks: assert property (
      @(posedge clk) disable iff (reset) flush |-> !in_ready);

    a_stall_hold: assert property (
      @(negedge clk) disable iff (reset)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
  end

endmodule

// File: tb/tb_la_dffnq_pipe.sv
// tb/tb_la_dffnq_pipe.sv - scoreboard bench for la_dffnq_pipe (WIDTH=8, DEPTH=3)

module tb_la_dffnq_pipe;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  localparam logic [7:0] W2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  localparam logic [7:0] W3 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int         idx;

  la_dffnq_pipe #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESETVAL (RV),
    .PROP     ("DEFAULT")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Clock held low until the reset-without-clock check is done.
  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample one time unit before each falling edge: push accepted words,
  // and drop everything expected when a flush lands on that edge.
  always @(posedge clk) begin
    #4;
    if (!reset) begin
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
    end
  end

  // Monitor: every word leaving the pipe must be the oldest expected word.
  always @(posedge clk) begin
    #4;
    if (!reset && !flush && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_word: got 0x%0h, expected no word", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_err++;
          $display("FAIL out_word: got 0x%0h, expected 0x%0h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] dt, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = dt;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset with no clock: outputs must take reset values immediately.
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_count", count, 0);
    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    // Streaming with out_ready=1: first word visible after the third edge.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, W2[k], 1'b1, 1'b0);
      chk("stream_in_ready", in_ready, 1);
      nedge();
      chk("stream_count", count, (k < 2) ? k + 1 : 3);
      chk("stream_out_valid", out_valid, (k >= 2) ? 1 : 0);
      if (k >= 2) chk("stream_out_data", out_data, W2[k-2]);
    end
    for (int j = 1; j <= 3; j++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nedge();
      chk("drain_count", count, 3 - j);
      chk("drain_out_valid", out_valid, (j < 3) ? 1 : 0);
    end

    // Stall: only three of five offers accepted, head word held.
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, W3[idx], 1'b0, 1'b0);
      chk("stall_in_ready", in_ready, (c < 3) ? 1 : 0);
      nedge();
      if (c < 3) idx++;
      chk("stall_count", count, (c < 2) ? c + 1 : 3);
      if (c >= 2) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, W3[0]);
      end
    end

    // Full pass-through: accept and emit on the same edge.
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, W3[idx], 1'b1, 1'b0);
      chk("full_in_ready", in_ready, 1);
      nedge();
      idx++;
      chk("full_count", count, 3);
      chk("full_out_data", out_data, W3[c+1]);
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nedge();
    end
    chk("full_drain_count", count, 0);
    chk("full_drain_out_valid", out_valid, 0);
    chk("held_out_data", out_data, W3[4]);

    // Flush at count=2 with in_valid=1.
    drive(1'b1, 8'hB0, 1'b0, 1'b0);
    nedge();
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    nedge();
    chk("pre_flush_count", count, 2);
    drive(1'b1, 8'hB2, 1'b0, 1'b1);
    chk("flush_in_ready", in_ready, 0);
    nedge();
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, RV);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    nedge();
    chk("post_flush_count", count, 0);

    // Flush of a full pipe while the output is being taken.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hF0 + 8'(k), 1'b0, 1'b0);
      nedge();
    end
    drive(1'b1, 8'hF3, 1'b1, 1'b1);
    chk("flushfull_out_valid", out_valid, 1);
    chk("flushfull_out_data", out_data, 8'hF0);
    chk("flushfull_in_ready", in_ready, 0);
    nedge();
    chk("flushfull_count", count, 0);
    chk("flushfull_out_data_rv", out_data, RV);

    // Input activity confined to the rising edge must not change state.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    in_valid = 1'b1; in_data = 8'hC0;
    #2;
    in_valid = 1'b0; in_data = 8'h00;
    nedge();
    chk("posedge_glitch_count", count, 0);
    chk("posedge_glitch_out_valid", out_valid, 0);
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    #2 in_data = 8'hC2;
    #2 in_data = 8'hC1;
    nedge();
    chk("posedge_data_count", count, 1);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nedge();
    end
    chk("posedge_drain_count", count, 0);

    // Reset mid-stream: contents dropped without a clock edge.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0);
      nedge();
    end
    chk("pre_reset_out_valid", out_valid, 1);
    chk("pre_reset_out_data", out_data, 8'hD0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, RV);
    chk("midrst_count", count, 0);
    exp_q.delete();
    nedge();
    reset = 1'b0;

    // Recovery after reset.
    drive(1'b1, 8'hE0, 1'b1, 1'b0);
    nedge();
    drive(1'b1, 8'hE1, 1'b1, 1'b0);
    nedge();
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nedge();
    end
    chk("recover_count", count, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
